// File: rtl/frame_reception_if.sv
// Byte-stream receive bus: the transmitter side drives rx_in/rx_en, and the receiver returns
// the parsed frame fields and status strobes.
interface frame_reception_if;
  logic [7:0]  rx_in;
  logic        rx_en;
  logic [47:0] dest_addr_out;
  logic [47:0] src_addr_out;
  logic [15:0] eth_type_out;
  logic [31:0] data_out;
  logic        rx_valid;
  logic        rx_error;
  logic        rx_busy;

  modport master (
    output rx_in, rx_en,
    input  dest_addr_out, src_addr_out, eth_type_out, data_out,
    input  rx_valid, rx_error, rx_busy
  );

  modport slave (
    input  rx_in, rx_en,
    output dest_addr_out, src_addr_out, eth_type_out, data_out,
    output rx_valid, rx_error, rx_busy
  );
endinterface

// File: rtl/frame_reception.sv
// MAC receive FSM: parses preamble/SFD/dest/src/type/payload/FCS, filters on destination
// address, and reports each frame with a one-cycle valid or error strobe.
module frame_reception #(
  parameter logic [47:0] MAC_ADDR     = 48'h0200_0000_0001,
  parameter int unsigned MIN_PREAMBLE = 7,
  parameter logic [7:0]  FCS_BYTE     = 8'hFF,
  parameter bit          PROMISC      = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  frame_reception_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, ETH_TYPE, PAYLOAD, FCS, DONE
  } state_e;

  localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [47:0] dest_sh_q, dest_sh_d;
  logic [47:0] src_sh_q, src_sh_d;
  logic [15:0] type_sh_q, type_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic        fcs_ok_q, fcs_ok_d;
  logic [47:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        in_field;
  logic        addr_ok;

  assign in_field = (state_q == DEST_ADDR) || (state_q == SRC_ADDR) ||
                    (state_q == ETH_TYPE)  || (state_q == PAYLOAD)  ||
                    (state_q == FCS);
  assign addr_ok  = PROMISC || (dest_sh_q == MAC_ADDR) || (dest_sh_q == '1);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    dest_sh_d  = dest_sh_q;
    src_sh_d   = src_sh_q;
    type_sh_d  = type_sh_q;
    data_sh_d  = data_sh_q;
    fcs_ok_d   = fcs_ok_q;
    dest_d     = dest_q;
    src_d      = src_q;
    type_d     = type_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    // Carrier loss inside the header/payload/FCS is a reportable abort.
    if (in_field && !bus.rx_en) begin
      error_d = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_en && bus.rx_in == 8'h55) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end
        end
        PREAMBLE: begin
          if (!bus.rx_en) begin
            state_d = IDLE;
          end else if (bus.rx_in == 8'h55) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (bus.rx_in == 8'hD5 && pre_cnt_q >= MIN_PRE) begin
            state_d    = DEST_ADDR;
            byte_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        DEST_ADDR: begin
          dest_sh_d  = {dest_sh_q[39:0], bus.rx_in};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd5) begin
            state_d    = SRC_ADDR;
            byte_cnt_d = '0;
          end
        end
        SRC_ADDR: begin
          src_sh_d   = {src_sh_q[39:0], bus.rx_in};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd5) begin
            state_d    = ETH_TYPE;
            byte_cnt_d = '0;
          end
        end
        ETH_TYPE: begin
          type_sh_d  = {type_sh_q[7:0], bus.rx_in};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd1) begin
            state_d    = PAYLOAD;
            byte_cnt_d = '0;
          end
        end
        PAYLOAD: begin
          data_sh_d  = {data_sh_q[23:0], bus.rx_in};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            state_d    = FCS;
            byte_cnt_d = '0;
          end
        end
        FCS: begin
          fcs_ok_d = (bus.rx_in == FCS_BYTE);
          state_d  = DONE;
        end
        DONE: begin
          if (!fcs_ok_q) begin
            error_d = 1'b1;
          end else if (addr_ok) begin
            dest_d  = dest_sh_q;
            src_d   = src_sh_q;
            type_d  = type_sh_q;
            data_d  = data_sh_q;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      dest_sh_q  <= '0;
      src_sh_q   <= '0;
      type_sh_q  <= '0;
      data_sh_q  <= '0;
      fcs_ok_q   <= 1'b0;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      dest_sh_q  <= dest_sh_d;
      src_sh_q   <= src_sh_d;
      type_sh_q  <= type_sh_d;
      data_sh_q  <= data_sh_d;
      fcs_ok_q   <= fcs_ok_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      type_q     <= type_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign bus.dest_addr_out = dest_q;
  assign bus.src_addr_out  = src_q;
  assign bus.eth_type_out  = type_q;
  assign bus.data_out      = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.rx_error      = error_q;
  assign bus.rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_reception.sv
// Bench for frame_reception: a directed frame table, hand-written latency/abort/reset
// sequences, and random frames scored against a frame-level outcome model.
module tb_frame_reception;
  localparam logic [47:0] MAC  = 48'h0200_0000_0001;
  localparam int          MINP = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_reception_if bus();

  frame_reception #(
    .MAC_ADDR    (MAC),
    .MIN_PREAMBLE(MINP),
    .FCS_BYTE    (8'hFF),
    .PROMISC     (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    int          pre_len;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] typ;
    logic [31:0] data;
    logic [7:0]  fcs;
    int          nbody;
    bit          exp_v;
    bit          exp_e;
  } vec_t;

  int n_checks = 0, n_pass = 0;
  int v_cnt = 0, e_cnt = 0, both_cnt = 0;
  logic [47:0] m_dest = '0, m_src = '0;
  logic [15:0] m_type = '0;
  logic [31:0] m_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) v_cnt++;
      if (bus.rx_error) e_cnt++;
      if (bus.rx_valid && bus.rx_error) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.rx_en = 1'b1;
    bus.rx_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_en = 1'b0;
      bus.rx_in = 8'($urandom);
    end
  endtask

  task automatic send_frame(input vec_t f);
    logic [151:0] flat;
    flat = {f.dest, f.src, f.typ, f.data, f.fcs};
    for (int i = 0; i < f.pre_len; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < f.nbody; i++) drive(flat[151-8*i -: 8]);
  endtask

  // Frame-level outcome from the reception rules; no cycle behaviour modelled.
  task automatic model(input vec_t f, output bit ev, output bit ee);
    ev = 1'b0;
    ee = 1'b0;
    if (f.pre_len < MINP)            ;
    else if (f.nbody < 19)           ee = 1'b1;
    else if (f.fcs != 8'hFF)         ee = 1'b1;
    else if (f.dest == MAC || f.dest == 48'hFFFF_FFFF_FFFF) ev = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/dest"}, 64'(bus.dest_addr_out), 64'(m_dest));
    check({tag, "/src"},  64'(bus.src_addr_out),  64'(m_src));
    check({tag, "/type"}, 64'(bus.eth_type_out),  64'(m_type));
    check({tag, "/data"}, 64'(bus.data_out),      64'(m_data));
  endtask

  task automatic run_and_check(input vec_t f, input bit ev, input bit ee);
    int v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    send_frame(f);
    idle(5);
    if (ev) begin
      m_dest = f.dest; m_src = f.src; m_type = f.typ; m_data = f.data;
    end
    check({f.name, "/valid_cnt"}, 64'(v_cnt - v0), 64'(ev));
    check({f.name, "/error_cnt"}, 64'(e_cnt - e0), 64'(ee));
    check({f.name, "/busy"}, 64'(bus.rx_busy), 64'd0);
    check_outputs(f.name);
  endtask

  vec_t vt[$];
  vec_t f;
  bit   ev, ee;
  int   v0, e0;

  initial begin
    bus.rx_en = 1'b0;
    bus.rx_in = 8'h00;

    vt.push_back('{"nominal2",  7, MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, 32'hDEAD_BEEF, 8'hFF, 19, 1'b1, 1'b0});
    vt.push_back('{"broadcast", 7, 48'hFFFF_FFFF_FFFF, 48'h1111_2222_3333, 16'h86DD, 32'h0102_0304, 8'hFF, 19, 1'b1, 1'b0});
    vt.push_back('{"addr_miss", 7, 48'h0200_0000_0002, 48'h4444_5555_6666, 16'h0806, 32'hCAFE_F00D, 8'hFF, 19, 1'b0, 1'b0});
    vt.push_back('{"fcs_err",   7, MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, 32'h1234_5678, 8'h00, 19, 1'b0, 1'b1});
    vt.push_back('{"pre5",      5, MAC, 48'h0, 16'h0, 32'h0, 8'hFF, 0, 1'b0, 1'b0});
    vt.push_back('{"pre6",      6, MAC, 48'h0, 16'h0, 32'h0, 8'hFF, 0, 1'b0, 1'b0});
    vt.push_back('{"pre15",    15, MAC, 48'hA1A2_A3A4_A5A6, 16'h0800, 32'h5555_5555, 8'hFF, 19, 1'b1, 1'b0});
    vt.push_back('{"pre20_sat",20, 48'hFFFF_FFFF_FFFF, 48'hB1B2_B3B4_B5B6, 16'h88CC, 32'h0000_0001, 8'hFF, 19, 1'b1, 1'b0});
    vt.push_back('{"abort_src3",7, MAC, 48'hC1C2_C3C4_C5C6, 16'h0800, 32'h7777_8888, 8'hFF, 9, 1'b0, 1'b1});
    vt.push_back('{"after_abort",7, MAC, 48'hD1D2_D3D4_D5D6, 16'h0801, 32'h9999_AAAA, 8'hFF, 19, 1'b1, 1'b0});
    vt.push_back('{"abort_sfd", 8, MAC, 48'h0, 16'h0, 32'h0, 8'hFF, 0, 1'b0, 1'b1});
    vt.push_back('{"abort_fcs", 7, MAC, 48'hE1E2_E3E4_E5E6, 16'h0800, 32'h1111_2222, 8'hFF, 18, 1'b0, 1'b1});

    repeat (3) @(negedge clk);
    check("reset/busy",  64'(bus.rx_busy),  64'd0);
    check("reset/valid", 64'(bus.rx_valid), 64'd0);
    check("reset/error", 64'(bus.rx_error), 64'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Nominal frame with exact strobe timing: DONE cycle, then one-cycle rx_valid.
    f = '{"nominal", 7, MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, 32'hDEAD_BEEF, 8'hFF, 19, 1'b1, 1'b0};
    send_frame(f);
    @(negedge clk); bus.rx_en = 1'b0;
    check("nominal/done_valid", 64'(bus.rx_valid), 64'd0);
    check("nominal/done_busy",  64'(bus.rx_busy),  64'd1);
    check_outputs("nominal/before");
    @(negedge clk);
    check("nominal/valid_hi", 64'(bus.rx_valid), 64'd1);
    check("nominal/error_lo", 64'(bus.rx_error), 64'd0);
    m_dest = f.dest; m_src = f.src; m_type = f.typ; m_data = f.data;
    check_outputs("nominal/after");
    @(negedge clk);
    check("nominal/valid_1cyc", 64'(bus.rx_valid), 64'd0);
    idle(3);

    foreach (vt[i]) run_and_check(vt[i], vt[i].exp_v, vt[i].exp_e);

    // Carrier drop inside preamble: silent return to idle.
    v0 = v_cnt; e0 = e_cnt;
    repeat (4) drive(8'h55);
    idle(4);
    check("pre_drop/valid_cnt", 64'(v_cnt - v0), 64'd0);
    check("pre_drop/error_cnt", 64'(e_cnt - e0), 64'd0);
    check("pre_drop/busy", 64'(bus.rx_busy), 64'd0);

    // Reset asserted during payload clears everything with no strobe.
    v0 = v_cnt; e0 = e_cnt;
    f = '{"rst_mid", 7, MAC, 48'h1212_3434_5656, 16'h0800, 32'hABCD_EF01, 8'hFF, 16, 1'b0, 1'b0};
    send_frame(f);
    @(negedge clk);
    check("rst_mid/busy_pre", 64'(bus.rx_busy), 64'd1);
    rst_n = 1'b0;
    bus.rx_en = 1'b0;
    #1;
    m_dest = '0; m_src = '0; m_type = '0; m_data = '0;
    check_outputs("rst_mid");
    check("rst_mid/busy", 64'(bus.rx_busy), 64'd0);
    check("rst_mid/valid", 64'(bus.rx_valid), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("rst_mid/valid_cnt", 64'(v_cnt - v0), 64'd0);
    check("rst_mid/error_cnt", 64'(e_cnt - e0), 64'd0);
    f = '{"post_rst", 7, MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, 32'hDEAD_BEEF, 8'hFF, 19, 1'b1, 1'b0};
    run_and_check(f, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      f.name    = $sformatf("rnd%0d", n);
      f.pre_len = int'($urandom_range(20, 5));
      case ($urandom_range(3))
        0, 3:    f.dest = MAC;
        1:       f.dest = 48'hFFFF_FFFF_FFFF;
        default: f.dest = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      endcase
      f.src  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      f.typ  = 16'($urandom);
      f.data = $urandom;
      f.fcs  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      if (f.pre_len < MINP)                f.nbody = 0;
      else if ($urandom_range(4) == 0)     f.nbody = int'($urandom_range(18, 0));
      else                                 f.nbody = 19;
      model(f, ev, ee);
      run_and_check(f, ev, ee);
    end

    check("never_both", 64'(both_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
